// File: rtl/cv32e40p_obi_stall_responder.sv
// cv32e40p_obi_stall_responder
// OBI data-side subordinate with programmable grant stalls, per-transaction
// response delays, an in-order response queue and a word-addressed RAM.
// Optional initiator protocol checker: define OBI_RESP_PROTOCOL_CHECK_EN.
`timescale 1ns/1ps
module cv32e40p_obi_stall_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DELAY_WIDTH     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               data_req_i,
  output logic                               data_gnt_o,
  input  logic [31:0]                        data_addr_i,
  input  logic                               data_we_i,
  input  logic [3:0]                         data_be_i,
  input  logic [31:0]                        data_wdata_i,
  output logic                               data_rvalid_o,
  output logic [31:0]                        data_rdata_o,
  input  logic [DELAY_WIDTH-1:0]             gnt_delay_i,
  input  logic [DELAY_WIDTH-1:0]             rvalid_delay_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               protocol_err_o
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int QPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]            r_mem     [MEM_WORDS];
  logic [31:0]            r_q_rdata [MAX_OUTSTANDING];
  logic [DELAY_WIDTH-1:0] r_q_cnt   [MAX_OUTSTANDING];
  logic [QPW-1:0]         r_head;
  logic [QPW-1:0]         r_tail;
  logic [OW-1:0]          r_occ;
  logic [DELAY_WIDTH-1:0] r_stall_cnt;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;

  logic [AW-1:0]          w_idx;
  logic                   w_gnt;
  logic                   w_push;
  logic                   w_bypass;
  logic                   w_store;
  logic                   w_pop;
  logic [31:0]            w_acc_rdata;
  logic [DELAY_WIDTH-1:0] w_store_cnt;

  // Word index wraps modulo the RAM size; byte offset bits are ignored.
  assign w_idx       = data_addr_i[AW+1:2];
  // Queue full blocks the grant even if the head pops this cycle.
  assign w_gnt       = data_req_i && (r_stall_cnt >= gnt_delay_i) &&
                       (r_occ < OW'(MAX_OUTSTANDING));
  assign w_push      = data_req_i && w_gnt;
  // Read data is captured at the accepting edge; writes respond with zero.
  assign w_acc_rdata = data_we_i ? 32'h0 : r_mem[w_idx];
  assign w_pop       = (r_occ != '0) && (r_q_cnt[r_head] == '0);
  // An entry counts its accept cycle as its first countdown cycle, so a
  // zero-delay access into an empty queue responds straight from the accept.
  assign w_bypass    = w_push && (r_occ == '0) && (rvalid_delay_i == '0);
  assign w_store     = w_push && !w_bypass;
  assign w_store_cnt = (rvalid_delay_i == '0) ? '0 : rvalid_delay_i - DELAY_WIDTH'(1);

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign outstanding_o = r_occ;

  // RAM byte-lane writes on accepted write requests; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_push && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Queue payload: countdowns tick toward zero; the tail slot is loaded on store.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_q_cnt[i] != '0) r_q_cnt[i] <= r_q_cnt[i] - DELAY_WIDTH'(1);
    end
    if (w_store) begin
      r_q_cnt[r_tail]   <= w_store_cnt;
      r_q_rdata[r_tail] <= w_acc_rdata;
    end
  end

  // Queue pointers, occupancy, grant stall counter and registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_stall_cnt <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_store) r_tail <= (r_tail == QPW'(MAX_OUTSTANDING - 1)) ? '0 : r_tail + QPW'(1);
      if (w_pop)   r_head <= (r_head == QPW'(MAX_OUTSTANDING - 1)) ? '0 : r_head + QPW'(1);
      r_occ <= r_occ + OW'(w_store) - OW'(w_pop);
      if (!data_req_i || w_gnt)      r_stall_cnt <= '0;
      else if (r_stall_cnt != '1)    r_stall_cnt <= r_stall_cnt + DELAY_WIDTH'(1);
      r_rvalid <= w_pop || w_bypass;
      r_rdata  <= w_pop ? r_q_rdata[r_head] : (w_bypass ? w_acc_rdata : 32'h0);
    end
  end

`ifdef OBI_RESP_PROTOCOL_CHECK_EN
  logic        r_pend;
  logic        r_err;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        w_viol;

  // A pending (ungranted) request must stay asserted with stable attributes.
  assign w_viol = r_pend && (!data_req_i || (data_addr_i != r_addr) ||
                  (data_we_i != r_we) || (data_be_i != r_be) ||
                  (r_we && (data_wdata_i != r_wdata)));
  assign protocol_err_o = r_err;

  // Snapshot of the request attributes seen in the previous cycle.
  always_ff @(posedge clk_i) begin
    r_addr  <= data_addr_i;
    r_we    <= data_we_i;
    r_be    <= data_be_i;
    r_wdata <= data_wdata_i;
  end

  // Pending tracking and sticky violation flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= data_req_i && !w_gnt;
      r_err  <= r_err || w_viol;
    end
  end
`else
  logic w_unused_addr;

  // Address bits outside the word index only matter to the checker.
  assign w_unused_addr  = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
  assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_obi_stall_responder.sv
// Directed bench for cv32e40p_obi_stall_responder (default parameters).
`timescale 1ns/1ps
module tb_cv32e40p_obi_stall_responder;

`ifdef OBI_RESP_PROTOCOL_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req    = 1'b0;
  logic        gnt;
  logic [31:0] addr   = '0;
  logic        we     = 1'b0;
  logic [3:0]  be     = '0;
  logic [31:0] wdata  = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic [3:0]  gnt_dly = '0;
  logic [3:0]  rv_dly  = '0;
  logic [2:0]  outstanding;
  logic        perr;

  int n_cmp = 0;
  int n_mis = 0;

  cv32e40p_obi_stall_responder #(
    .MEM_WORDS(1024), .MAX_OUTSTANDING(4), .DELAY_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .gnt_delay_i(gnt_dly), .rvalid_delay_i(rv_dly),
    .outstanding_o(outstanding), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d;
    #1;
  endtask

  initial begin
    // Reset state
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    step(); step();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_perr", perr, 0);
    chk("rst_gnt", gnt, 0);
    rst_ni = 1'b1;
    step();

    // Zero delays: write then read 0x100
    drv(1, 1, 32'h100, 4'hF, 32'hDEADBEEF);
    chk("t1_wr_gnt", gnt, 1);
    step();
    drv(1, 0, 32'h100, 4'hF, 32'h0);
    chk("t1_rd_gnt", gnt, 1);
    chk("t1_wr_rvalid", rvalid, 1);
    chk("t1_wr_rdata", rdata, 0);
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t1_rd_rvalid", rvalid, 1);
    chk("t1_rd_rdata", rdata, 32'hDEADBEEF);
    chk("t1_outstanding", outstanding, 0);
    step();
    chk("t1_idle_rvalid", rvalid, 0);
    chk("t1_idle_rdata", rdata, 0);

    // Grant stall of 3 cycles, twice in a row
    gnt_dly = 4'd3;
    drv(1, 0, 32'h100, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_gnt_a%0d", i), gnt, 32'(i == 3));
      step();
    end
    chk("t2_rvalid_a", rvalid, 1);
    chk("t2_rdata_a", rdata, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_gnt_b%0d", i), gnt, 32'(i == 3));
      step();
    end
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t2_rvalid_b", rvalid, 1);
    step();
    chk("t2_rvalid_off", rvalid, 0);
    gnt_dly = 4'd0;

    // Outstanding limit with rvalid delay 10
    rv_dly = 4'd10;
    drv(1, 0, 32'h100, 4'hF, 32'h0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t3_gnt_%0d", i), gnt, 32'((i < 4) || (i == 11)));
      chk($sformatf("t3_out_%0d", i), outstanding, (i < 4) ? i : ((i < 11) ? 4 : 3));
      chk($sformatf("t3_rvalid_%0d", i), rvalid, 32'(i == 11));
      chk($sformatf("t3_rdata_%0d", i), rdata, (i == 11) ? 32'hDEADBEEF : 32'h0);
      step();
    end
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    rv_dly = 4'd0;
    for (int i = 12; i < 24; i++) begin
      chk($sformatf("t3_drain_rvalid_%0d", i), rvalid, 32'((i <= 14) || (i == 22)));
      chk($sformatf("t3_drain_out_%0d", i), outstanding,
          (i == 12) ? 3 : ((i == 13) ? 2 : ((i <= 21) ? 1 : 0)));
      step();
    end

    // Byte enables
    drv(1, 1, 32'h0, 4'hF, 32'h11223344);
    chk("t4_wr1_gnt", gnt, 1);
    step();
    drv(1, 1, 32'h0, 4'b0101, 32'hAABBCCDD);
    chk("t4_wr2_gnt", gnt, 1);
    chk("t4_wr1_rvalid", rvalid, 1);
    chk("t4_wr1_rdata", rdata, 0);
    step();
    drv(1, 0, 32'h0, 4'hF, 32'h0);
    chk("t4_rd_gnt", gnt, 1);
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t4_rd_rvalid", rvalid, 1);
    chk("t4_rd_rdata", rdata, 32'h11BB33DD);
    step();

    // Ordering: slow read A then fast read B
    rv_dly = 4'd8;
    drv(1, 0, 32'h0, 4'hF, 32'h0);
    chk("t5_a_gnt", gnt, 1);
    step();
    rv_dly = 4'd0;
    drv(1, 0, 32'h100, 4'hF, 32'h0);
    chk("t5_b_gnt", gnt, 1);
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    for (int i = 2; i < 12; i++) begin
      chk($sformatf("t5_rvalid_%0d", i), rvalid, 32'((i == 9) || (i == 10)));
      chk($sformatf("t5_rdata_%0d", i), rdata,
          (i == 9) ? 32'h11BB33DD : ((i == 10) ? 32'hDEADBEEF : 32'h0));
      step();
    end

    // Address wrap: 0x1000 aliases word 0
    drv(1, 1, 32'h1000, 4'hF, 32'h5A5A5A5A);
    chk("t6_wr_gnt", gnt, 1);
    step();
    drv(1, 0, 32'h0, 4'hF, 32'h0);
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t6_rvalid", rvalid, 1);
    chk("t6_rdata", rdata, 32'h5A5A5A5A);
    step();

    // Reset with two outstanding and rvalid high
    rv_dly = 4'd2;
    drv(1, 0, 32'h100, 4'hF, 32'h0);
    step();
    rv_dly = 4'd5;
    step();
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t7_pre_rvalid", rvalid, 1);
    chk("t7_pre_rdata", rdata, 32'hDEADBEEF);
    chk("t7_pre_out", outstanding, 2);
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_rvalid", rvalid, 0);
    chk("t7_rst_rdata", rdata, 0);
    chk("t7_rst_out", outstanding, 0);
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t7_stale_%0d", i), rvalid, 0);
      step();
    end
    rv_dly = 4'd0;
    drv(1, 0, 32'h0, 4'hF, 32'h0);
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    chk("t7_ram_kept", rdata, 32'h5A5A5A5A);
    step();

    // Protocol: address changes during a grant stall
    gnt_dly = 4'd2;
    drv(1, 0, 32'h0, 4'hF, 32'h0);
    chk("t8_gnt0", gnt, 0);
    chk("t8_perr0", perr, 0);
    step();
    drv(1, 0, 32'h4, 4'hF, 32'h0);
    chk("t8_gnt1", gnt, 0);
    chk("t8_perr1", perr, 0);
    step();
    chk("t8_gnt2", gnt, 1);
    chk("t8_perr2", perr, 32'(PERR_EXP));
    step();
    drv(0, 0, 32'h0, 4'h0, 32'h0);
    step();
    step();
    chk("t8_perr_held", perr, 32'(PERR_EXP));
    rst_ni = 1'b0;
    #1;
    chk("t8_perr_rst", perr, 0);
    step();
    rst_ni = 1'b1;
    step();
    chk("t8_perr_after", perr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
